// File: rtl/npu_mac_pkg.sv
// Shared definitions for the NPU multiply-accumulate datapath:
// default widths, MAC FSM state encoding and saturation bounds.
package npu_mac_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 24;
  localparam int OUT_W_DEF  = 16;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DRAIN,
    DONE
  } mac_state_t;

  localparam logic [OUT_W_DEF-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [OUT_W_DEF-1:0] SAT_MIN = 16'h8000;

endpackage

// File: rtl/mac_saturate.sv
// Combinational signed clamp from the accumulator width down to the
// result width, flagging when the clamp was applied.
module mac_saturate
  import npu_mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic [ACC_W-1:0] acc,
  output logic [OUT_W-1:0] result,
  output logic             overflow
);

  logic [ACC_W-OUT_W:0] hi;

  // In range only when every bit above the result sign bit matches it.
  always_comb begin
    hi       = acc[ACC_W-1:OUT_W-1];
    overflow = !((&hi) || (~|hi));
    result   = acc[OUT_W-1:0];
    if (overflow) begin
      result = acc[ACC_W-1] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/mac_accum_unit.sv
// Signed MAC burst unit: multiply register, accumulate register,
// then a saturated result with a one-cycle strobe for the ReLU stage.
module mac_accum_unit
  import npu_mac_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              CLK,
  input  logic              RST_MAC,
  input  logic              Start,
  input  logic [CNT_W-1:0]  Num_Terms,
  input  logic [DATA_W-1:0] Data_A,
  input  logic [DATA_W-1:0] Data_B,
  input  logic              Data_Valid,
  output logic              Busy,
  output logic [OUT_W-1:0]  Data_Reg,
  output logic              En_MAC_ReLU,
  output logic              Overflow
);

  localparam int PROD_W = 2 * DATA_W;

  mac_state_t state;
  mac_state_t state_nx;

  logic [CNT_W-1:0] n_lat;
  logic [CNT_W-1:0] issued;
  logic [CNT_W-1:0] count;

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic signed [PROD_W-1:0] prod;
  logic                     prod_valid;
  logic signed [ACC_W-1:0]  acc;

  logic [OUT_W-1:0] sat_val;
  logic             sat_ovf;

  logic start_ok;
  logic zero_burst;
  logic take_pair;
  logic last_pair;
  logic drain_done;
  logic fire;

  assign a_s = Data_A;
  assign b_s = Data_B;

  mac_saturate #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_sat (
    .acc      (acc),
    .result   (sat_val),
    .overflow (sat_ovf)
  );

  // State register.
  always_ff @(posedge CLK or posedge RST_MAC) begin
    if (RST_MAC) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (zero_burst) begin
          state_nx = DONE;
        end else if (start_ok) begin
          state_nx = ACC;
        end
      end
      ACC: begin
        if (last_pair) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_done) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Per-state control strobes for the datapath and output registers.
  always_comb begin
    start_ok   = (state == IDLE) && Start;
    zero_burst = start_ok && (Num_Terms == '0);
    take_pair  = (state == ACC) && Data_Valid;
    last_pair  = take_pair && (issued == n_lat - 1'b1);
    drain_done = (state == DRAIN) && (count == n_lat);
    fire       = (state == DONE);
  end

  // Stage 1: register the signed product of each accepted pair.
  always_ff @(posedge CLK or posedge RST_MAC) begin
    if (RST_MAC) begin
      prod       <= '0;
      prod_valid <= 1'b0;
    end else begin
      prod_valid <= take_pair;
      if (take_pair) begin
        prod <= PROD_W'(a_s) * PROD_W'(b_s);
      end
    end
  end

  // Stage 2: burst bookkeeping and full-precision accumulation.
  always_ff @(posedge CLK or posedge RST_MAC) begin
    if (RST_MAC) begin
      n_lat  <= '0;
      issued <= '0;
      count  <= '0;
      acc    <= '0;
    end else if (start_ok) begin
      n_lat  <= Num_Terms;
      issued <= '0;
      count  <= '0;
      acc    <= '0;
    end else begin
      if (take_pair) begin
        issued <= issued + 1'b1;
      end
      if (prod_valid) begin
        acc   <= acc + ACC_W'(prod);
        count <= count + 1'b1;
      end
    end
  end

  // Registered outputs: result and flag held until the next burst ends.
  always_ff @(posedge CLK or posedge RST_MAC) begin
    if (RST_MAC) begin
      Busy        <= 1'b0;
      Data_Reg    <= '0;
      En_MAC_ReLU <= 1'b0;
      Overflow    <= 1'b0;
    end else begin
      Busy        <= (state_nx != IDLE);
      En_MAC_ReLU <= fire;
      if (fire) begin
        Data_Reg <= sat_val;
        Overflow <= sat_ovf;
      end
    end
  end

endmodule
